// File: rtl/booth4_controller.sv
// Radix-4 Booth multiplier controller.
// Sequences LOAD, then EVAL/SHIFT/CHECK per digit pair, then DONE.
module booth4_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       Q1,
    input  logic       Q0,
    input  logic       Qm1,
    input  logic       eqz,
    output logic       ldA,
    output logic       shiftA,
    output logic       clrA,
    output logic       ldQ,
    output logic       shiftQ,
    output logic       clrQ,
    output logic       decr,
    output logic       ld_count,
    output logic       clrff,
    output logic       ldM,
    output logic       clrM,
    output logic [1:0] ALU_op,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        SHIFT = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;

    // State register; reset lands in IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; abort overrides everything outside IDLE.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = EVAL;
            EVAL:    state_d = SHIFT;
            SHIFT:   state_d = CHECK;
            CHECK:   state_d = eqz ? DONE : EVAL;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    // Output decode from state, plus the Booth triplet in EVAL.
    always_comb begin
        ldA      = 1'b0;
        shiftA   = 1'b0;
        clrA     = 1'b0;
        ldQ      = 1'b0;
        shiftQ   = 1'b0;
        clrQ     = 1'b0;
        decr     = 1'b0;
        ld_count = 1'b0;
        clrff    = 1'b0;
        ldM      = 1'b0;
        clrM     = 1'b0;
        ALU_op   = 2'b00;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            LOAD: begin
                busy     = 1'b1;
                ldQ      = 1'b1;
                ldM      = 1'b1;
                clrA     = 1'b1;
                clrff    = 1'b1;
                ld_count = 1'b1;
            end
            EVAL: begin
                busy = 1'b1;
                case ({Q1, Q0, Qm1})
                    3'b001, 3'b010: begin
                        ldA    = 1'b1;
                        ALU_op = 2'b00;
                    end
                    3'b011: begin
                        ldA    = 1'b1;
                        ALU_op = 2'b01;
                    end
                    3'b101, 3'b110: begin
                        ldA    = 1'b1;
                        ALU_op = 2'b10;
                    end
                    3'b100: begin
                        ldA    = 1'b1;
                        ALU_op = 2'b11;
                    end
                    default: begin
                        ldA    = 1'b0;
                        ALU_op = 2'b00;
                    end
                endcase
            end
            SHIFT: begin
                busy   = 1'b1;
                shiftA = 1'b1;
                shiftQ = 1'b1;
                decr   = 1'b1;
            end
            CHECK: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_booth4_controller.sv
// Directed bench for booth4_controller.
// A behavioural radix-4 datapath closes the loop around the controller.
module tb_booth4_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       q1, q0, qm1, eqz;
    logic       ldA, shiftA, clrA, ldQ, shiftQ, clrQ;
    logic       decr, ld_count, clrff, ldM, clrM;
    logic [1:0] alu_op;
    logic       busy, done;

    int n_tests = 0;
    int n_fail = 0;
    int excl_viol = 0;

    logic       ovr = 1'b0;
    logic [2:0] ovr_val = 3'b000;
    logic [7:0] m_in = '0;
    logic [7:0] q_in = '0;

    logic signed [9:0] a_r = '0;
    logic [7:0]        q_r = '0;
    logic [7:0]        m_r = '0;
    logic              qm1_r = 1'b0;
    logic [2:0]        cnt_r = '0;
    logic signed [9:0] m_ext;
    logic [15:0]       prod;
    logic [14:0]       all_o;

    always #5 clk = ~clk;

    booth4_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .Q1(q1), .Q0(q0), .Qm1(qm1), .eqz(eqz),
        .ldA(ldA), .shiftA(shiftA), .clrA(clrA), .ldQ(ldQ),
        .shiftQ(shiftQ), .clrQ(clrQ), .decr(decr),
        .ld_count(ld_count), .clrff(clrff), .ldM(ldM), .clrM(clrM),
        .ALU_op(alu_op), .busy(busy), .done(done)
    );

    assign m_ext = {{2{m_r[7]}}, m_r};
    assign prod  = {a_r[7:0], q_r};
    assign eqz   = (cnt_r == 3'd0);
    assign {q1, q0, qm1} = ovr ? ovr_val : {q_r[1], q_r[0], qm1_r};
    assign all_o = {ldA, shiftA, clrA, ldQ, shiftQ, clrQ, decr,
                    ld_count, clrff, ldM, clrM, alu_op, busy, done};

    // Datapath model: A is 10 bits so +-2M never overflows.
    always @(posedge clk) begin
        if (clrA) a_r <= '0;
        else if (ldA) begin
            case (alu_op)
                2'b00: a_r <= a_r + m_ext;
                2'b01: a_r <= a_r + (m_ext <<< 1);
                2'b10: a_r <= a_r - m_ext;
                default: a_r <= a_r - (m_ext <<< 1);
            endcase
        end else if (shiftA) a_r <= a_r >>> 2;
        if (ldQ) q_r <= q_in;
        else if (shiftQ) q_r <= {a_r[1:0], q_r[7:2]};
        if (clrff) qm1_r <= 1'b0;
        else if (shiftQ) qm1_r <= q_r[1];
        if (ldM) m_r <= m_in;
        if (ld_count) cnt_r <= 3'd4;
        else if (decr) cnt_r <= cnt_r - 3'd1;
    end

    always @(negedge clk) begin
        if (int'(ldA) + int'(shiftA) + int'(ld_count) > 1) excl_viol++;
        if (int'(ldA) + int'(shiftQ) + int'(ld_count) > 1) excl_viol++;
    end

    task automatic run_mul(input logic [7:0] m, input logic [7:0] q,
                           output int d_at, output int b_n,
                           output int d_n, output logic [15:0] p,
                           output logic [3:0] lda_s,
                           output logic [7:0] op_s);
        m_in = m;
        q_in = q;
        d_at = 0;
        b_n = 0;
        d_n = 0;
        p = '0;
        lda_s = '0;
        op_s = '0;
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) b_n++;
            if (done) begin
                d_n++;
                if (d_at == 0) begin
                    d_at = i;
                    p = prod;
                end
            end
            if (i >= 2 && i <= 11 && (i - 2) % 3 == 0) begin
                lda_s[(i - 2) / 3] = ldA;
                op_s[2 * ((i - 2) / 3) +: 2] = alu_op;
            end
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #11;
        n_tests++;
        if (all_o !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0000", all_o);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int d_at, b_n, d_n;
        logic [15:0] p;
        logic [3:0] ls;
        logic [7:0] os;
        run_mul(8'd7, 8'd3, d_at, b_n, d_n, p, ls, os);
        n_tests++;
        if (d_at !== 14) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 14", d_at);
        end
        n_tests++;
        if (b_n !== 14) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d want 14", b_n);
        end
        n_tests++;
        if (d_n !== 1) begin
            n_fail++;
            $display("FAIL basic_done_width: got %0d want 1", d_n);
        end
        n_tests++;
        if (p !== 16'h0015) begin
            n_fail++;
            $display("FAIL basic_product: got %h want 0015", p);
        end
    endtask

    task automatic test_signed;
        int d_at, b_n, d_n;
        logic [15:0] p;
        logic [3:0] ls;
        logic [7:0] os;
        run_mul(8'hFB, 8'd7, d_at, b_n, d_n, p, ls, os);
        n_tests++;
        if (p !== 16'hFFDD) begin
            n_fail++;
            $display("FAIL signed_product: got %h want ffdd", p);
        end
        n_tests++;
        if (ls !== 4'b0011) begin
            n_fail++;
            $display("FAIL signed_ldA_seq: got %b want 0011", ls);
        end
        // Booth digits of 7, low pair first: -1, +2, 0, 0.
        n_tests++;
        if (os !== 8'b00_00_01_10) begin
            n_fail++;
            $display("FAIL signed_op_seq: got %b want 00000110", os);
        end
    endtask

    task automatic test_decode_sweep;
        logic       exp_lda;
        logic [1:0] exp_op;
        ovr = 1'b1;
        for (int t = 0; t < 8; t++) begin
            ovr_val = 3'(t);
            case (t)
                0: begin exp_lda = 1'b0; exp_op = 2'b00; end
                1: begin exp_lda = 1'b1; exp_op = 2'b00; end
                2: begin exp_lda = 1'b1; exp_op = 2'b00; end
                3: begin exp_lda = 1'b1; exp_op = 2'b01; end
                4: begin exp_lda = 1'b1; exp_op = 2'b11; end
                5: begin exp_lda = 1'b1; exp_op = 2'b10; end
                6: begin exp_lda = 1'b1; exp_op = 2'b10; end
                default: begin exp_lda = 1'b0; exp_op = 2'b00; end
            endcase
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            n_tests++;
            if ({ldA, alu_op, shiftA} !== {exp_lda, exp_op, 1'b0}) begin
                n_fail++;
                $display("FAIL decode_%0d: got ldA=%b op=%b sh=%b want ldA=%b op=%b sh=0",
                         t, ldA, alu_op, shiftA, exp_lda, exp_op);
            end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        ovr = 1'b0;
    endtask

    task automatic test_back_to_back;
        int d1, d2;
        logic b15;
        logic [15:0] p1, p2;
        d1 = 0;
        d2 = 0;
        b15 = 1'b1;
        p1 = '0;
        p2 = '0;
        m_in = 8'd7;
        q_in = 8'd3;
        start = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin
                m_in = 8'd3;
                q_in = 8'hFE;
            end
            if (i == 15) b15 = busy;
            if (i == 16) start = 1'b0;
            if (done && d1 == 0) begin
                d1 = i;
                p1 = prod;
            end else if (done && d2 == 0) begin
                d2 = i;
                p2 = prod;
            end
        end
        start = 1'b0;
        n_tests++;
        if (d1 !== 14 || d2 !== 29) begin
            n_fail++;
            $display("FAIL b2b_done_times: got %0d,%0d want 14,29", d1, d2);
        end
        n_tests++;
        if (b15 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: busy got %b want 0", b15);
        end
        n_tests++;
        if (p1 !== 16'h0015 || p2 !== 16'hFFFA) begin
            n_fail++;
            $display("FAIL b2b_products: got %h,%h want 0015,fffa", p1, p2);
        end
    endtask

    task automatic test_busy_abort;
        int d_seen, idle_busy, d_at, b_n, d_n;
        logic b8;
        logic [15:0] p;
        logic [3:0] ls;
        logic [7:0] os;
        d_seen = 0;
        idle_busy = 0;
        b8 = 1'b1;
        m_in = 8'd1;
        q_in = 8'd1;
        start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (i == 6) start = 1'b1;
            if (i == 7) begin
                start = 1'b0;
                abort = 1'b1;
            end
            if (i == 8) begin
                abort = 1'b0;
                b8 = busy;
            end
            if (i > 8 && busy) idle_busy++;
            if (done) d_seen++;
        end
        n_tests++;
        if (b8 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_to_idle: busy got %b want 0", b8);
        end
        n_tests++;
        if (idle_busy !== 0 || d_seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_restart: busy_cycles=%0d done=%0d want 0,0",
                     idle_busy, d_seen);
        end
        run_mul(8'hFD, 8'd5, d_at, b_n, d_n, p, ls, os);
        n_tests++;
        if (d_at !== 14 || p !== 16'hFFF1) begin
            n_fail++;
            $display("FAIL abort_fresh_mul: got t=%0d p=%h want t=14 p=fff1",
                     d_at, p);
        end
    endtask

    task automatic test_idle_abort;
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if ({busy, ld_count} !== 2'b11) begin
            n_fail++;
            $display("FAIL start_abort_idle: busy,ld_count got %b want 11",
                     {busy, ld_count});
        end
        @(posedge clk); #1;
        abort = 1'b0;
        n_tests++;
        if (all_o !== 15'd0) begin
            n_fail++;
            $display("FAIL abort_in_load: got %h want 0000", all_o);
        end
    endtask

    task automatic test_reset_mid;
        int d_at, b_n, d_n;
        logic [15:0] p;
        logic [3:0] ls;
        logic [7:0] os;
        m_in = 8'd5;
        q_in = 8'd9;
        start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (all_o !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h want 0000", all_o);
        end
        #2 rst_n = 1'b1;
        run_mul(8'h80, 8'h80, d_at, b_n, d_n, p, ls, os);
        n_tests++;
        if (d_at !== 14 || p !== 16'h4000) begin
            n_fail++;
            $display("FAIL reset_then_mul: got t=%0d p=%h want t=14 p=4000",
                     d_at, p);
        end
    endtask

    task automatic test_exclusive;
        n_tests++;
        if (excl_viol !== 0) begin
            n_fail++;
            $display("FAIL exclusive_controls: got %0d overlaps want 0",
                     excl_viol);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signed;
        test_decode_sweep;
        test_back_to_back;
        test_busy_abort;
        test_idle_abort;
        test_reset_mid;
        test_exclusive;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
